// File: rtl/pipeline_skid_register.sv
// Inter-stage pipeline register with a 2-entry skid buffer and registered ready.
// Flush kills held entries; a saturating counter tracks downstream stall cycles.
module pipeline_skid_register #(
  parameter int                  DATA_WIDTH  = 128,
  parameter int                  CTRL_WIDTH  = 24,
  parameter logic [CTRL_WIDTH-1:0] BUBBLE_CTRL = '0,
  parameter int                  COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [CTRL_WIDTH-1:0]  in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [CTRL_WIDTH-1:0]  out_ctrl,
  output logic [COUNT_WIDTH-1:0] stall_count,
  input  logic                   clear_count
);

  // State bits are {main_valid, skid_valid}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0]  main_data_q, skid_data_q;
  logic [CTRL_WIDTH-1:0]  main_ctrl_q, skid_ctrl_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic main_valid, skid_valid;
  logic accept, drain;
  logic load_main, load_skid, pop_skid;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign out_ctrl  = main_valid ? main_ctrl_q : BUBBLE_CTRL;

  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (drain) begin
          state_d   = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          pop_skid = 1'b1;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload flops only move on their enables; flush leaves them stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
    end else if (load_main) begin
      main_data_q <= in_data;
      main_ctrl_q <= in_ctrl;
    end else if (pop_skid) begin
      main_data_q <= skid_data_q;
      main_ctrl_q <= skid_ctrl_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (load_skid) begin
      skid_data_q <= in_data;
      skid_ctrl_q <= in_ctrl;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (main_valid && !out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

  a_no_orphan_skid: assert property (
    @(posedge clk) disable iff (reset)
    !(!main_valid && skid_valid)
  );

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Randomised and directed bench for pipeline_skid_register.
// Reference model: a 2-deep FIFO queue plus a saturating integer counter.
module tb_pipeline_skid_register;

  localparam int DW = 128;
  localparam int CW = 24;
  localparam int NW = 16;
  localparam logic [CW-1:0] BUB = '0;
  localparam int CMAX = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic          out_valid, out_ready, clear_count;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [NW-1:0] stall_count;

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] md[$];
  logic [CW-1:0] mc[$];
  int            m_cnt = 0;

  always #5 clk = ~clk;

  pipeline_skid_register #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .BUBBLE_CTRL(BUB),
    .COUNT_WIDTH(NW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .stall_count(stall_count),
    .clear_count(clear_count)
  );

  // Drive one cycle of inputs and advance the model; returns at the negedge.
  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic [CW-1:0] c, input logic ordy,
                      input logic fl, input logic clr, input logic rst);
    int sz;
    bit acc, drn, stl;
    sz = md.size();
    in_valid    = v;
    in_data     = d;
    in_ctrl     = c;
    out_ready   = ordy;
    flush       = fl;
    clear_count = clr;
    reset       = rst;
    acc = v && (sz < 2);
    drn = (sz > 0) && ordy;
    stl = (sz > 0) && !ordy;
    @(posedge clk);
    if (rst) begin
      md.delete();
      mc.delete();
      m_cnt = 0;
    end else begin
      if (drn) begin
        void'(md.pop_front());
        void'(mc.pop_front());
      end
      if (fl) begin
        md.delete();
        mc.delete();
      end else if (acc) begin
        md.push_back(d);
        mc.push_back(c);
      end
      if (clr) m_cnt = 0;
      else if (stl && m_cnt < CMAX) m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk += 5;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got %0b want 0", out_valid);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %0b want 1", in_ready);
    end
    if (stall_count !== '0) begin
      n_fail++; $display("FAIL reset_count got %0d want 0", stall_count);
    end
    if (out_ctrl !== BUB) begin
      n_fail++; $display("FAIL reset_ctrl got %h want %h", out_ctrl, BUB);
    end
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", out_data);
    end
  endtask

  task automatic test_single();
    step(1'b1, DW'(64'h40), CW'(24'h123), 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk += 4;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_valid got %0b want 1", out_valid);
    end
    if (out_data !== DW'(64'h40)) begin
      n_fail++; $display("FAIL single_data got %h want 40", out_data);
    end
    if (out_ctrl !== CW'(24'h123)) begin
      n_fail++; $display("FAIL single_ctrl got %h want 123", out_ctrl);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_ready got %0b want 1", in_ready);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_drain got %0b want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      n_chk += 2;
      if (out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid);
      end
      if (out_data !== DW'(i)) begin
        n_fail++; $display("FAIL stream_data[%0d] got %0d want %0d", i, out_data, i);
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (stall_count !== '0) begin
      n_fail++; $display("FAIL stream_count got %0d want 0", stall_count);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a, b, c;
    a = DW'(32'hA); b = DW'(32'hB); c = DW'(32'hC);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, a, CW'(1), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, b, CW'(2), 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk += 2;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_full got %0b want 0", in_ready);
    end
    if (out_data !== a) begin
      n_fail++; $display("FAIL bp_head got %h want A", out_data);
    end
    step(1'b1, c, CW'(3), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, c, CW'(3), 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk += 2;
    if (out_data !== a) begin
      n_fail++; $display("FAIL bp_hold got %h want A", out_data);
    end
    if (stall_count !== NW'(3)) begin
      n_fail++; $display("FAIL bp_count got %0d want 3", stall_count);
    end
    step(1'b1, c, CW'(3), 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk += 2;
    if (out_valid !== 1'b1 || out_data !== b) begin
      n_fail++; $display("FAIL bp_second got %h want B", out_data);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_one got %0b want 1", in_ready);
    end
    step(1'b1, c, CW'(3), 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk += 2;
    if (out_valid !== 1'b1 || out_data !== c) begin
      n_fail++; $display("FAIL bp_third got %h want C", out_data);
    end
    if (stall_count !== NW'(3)) begin
      n_fail++; $display("FAIL bp_count_end got %0d want 3", stall_count);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_empty got %0b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    step(1'b1, DW'(32'hD1), CW'(5), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(32'hD2), CW'(6), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(32'hD3), CW'(7), 1'b0, 1'b1, 1'b0, 1'b0);
    n_chk += 3;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid);
    end
    if (out_ctrl !== BUB) begin
      n_fail++; $display("FAIL flush_ctrl got %h want %h", out_ctrl, BUB);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_ready got %0b want 1", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      n_chk += 2;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_ghost[%0d] got %0b want 0", i, out_valid);
      end
      if (stall_count !== NW'(m_cnt)) begin
        n_fail++; $display("FAIL flush_count got %0d want %0d", stall_count, m_cnt);
      end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [CW-1:0] ec;
    logic          v, r, f, k;
    for (int i = 0; i < 2000; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      c = CW'($urandom);
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 31) == 0);
      k = ($urandom_range(0, 63) == 0);
      step(v, d, c, r, f, k, 1'b0);
      ec = (md.size() > 0) ? mc[0] : BUB;
      n_chk += 4;
      if (out_valid !== (md.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, out_valid, md.size() > 0);
      end
      if (in_ready !== (md.size() < 2)) begin
        n_fail++; $display("FAIL rnd_ready[%0d] got %0b want %0b", i, in_ready, md.size() < 2);
      end
      if (out_ctrl !== ec) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d] got %h want %h", i, out_ctrl, ec);
      end
      if (stall_count !== NW'(m_cnt)) begin
        n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, stall_count, m_cnt);
      end
      if (md.size() > 0) begin
        n_chk++;
        if (out_data !== md[0]) begin
          n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", i, out_data, md[0]);
        end
      end
    end
    step(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, DW'(5), CW'(5), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_chk++;
    if (stall_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_near got %h want fffe", stall_count);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_chk++;
    if (stall_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_top got %h want ffff", stall_count);
    end
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_chk++;
    if (stall_count !== '0) begin
      n_fail++; $display("FAIL sat_clear got %h want 0", stall_count);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_full();
    step(1'b1, DW'(32'hE1), CW'(8), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(32'hE2), CW'(9), 1'b0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rf_full got %0b want 0", in_ready);
    end
    step(1'b1, DW'(32'hE3), CW'(10), 1'b0, 1'b0, 1'b0, 1'b1);
    n_chk += 5;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rf_valid got %0b want 0", out_valid);
    end
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rf_ready got %0b want 1", in_ready);
    end
    if (stall_count !== '0) begin
      n_fail++; $display("FAIL rf_count got %0d want 0", stall_count);
    end
    if (out_data !== '0) begin
      n_fail++; $display("FAIL rf_data got %h want 0", out_data);
    end
    if (out_ctrl !== BUB) begin
      n_fail++; $display("FAIL rf_ctrl got %h want %h", out_ctrl, BUB);
    end
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rf_after got %0b want 0", out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_count = 1'b0; in_data = '0; in_ctrl = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_saturation();
    test_reset_full();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_skid_register.md
Name: pipeline_skid_register

Overview:
- Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) that replaces plain write-enabled stage registers.
- Carries a data payload (PC, operands, immediate) and a control payload (operator selects, write enables) with a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path across stages.
- Supports flush, which kills in-flight instructions and emits bubbles, and counts stall cycles for performance tuning.

Parameters:
- DATA_WIDTH, 128, width of the data payload (e.g. pc, rs1, rs2, imm concatenated).
- CTRL_WIDTH, 24, width of the control payload (rd address, alu/pc/reg/ram controls).
- BUBBLE_CTRL, 0 (CTRL_WIDTH bits), value driven on out_ctrl whenever out_valid=0; must encode reg_wren=0 and ram_wren=0.
- COUNT_WIDTH, 16, width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all held entries and the same-cycle input (branch mispredict, jump).
- in_valid  input  1  upstream presents a valid instruction.
- in_ready  output  1  register can accept; registered, equals !skid_valid.
- in_data  input  DATA_WIDTH  upstream data payload.
- in_ctrl  input  CTRL_WIDTH  upstream control payload.
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_WIDTH  head entry data.
- out_ctrl  output  CTRL_WIDTH  head entry control; BUBBLE_CTRL when out_valid=0.
- stall_count  output  COUNT_WIDTH  saturating count of cycles with out_valid=1 and out_ready=0.
- clear_count  input  1  synchronous clear of stall_count.

Behaviour:
- Storage: main entry (main_valid, main_data, main_ctrl) drives the outputs; skid entry (skid_valid, skid_data, skid_ctrl) holds overflow.
- out_valid=main_valid; out_data=main_data; out_ctrl=main_valid ? main_ctrl : BUBBLE_CTRL.
- in_ready=!skid_valid, driven from the flop only.
- Accept = in_valid & in_ready. Drain = main_valid & out_ready.
- State encoding (main_valid, skid_valid): EMPTY=(0,0), ONE=(1,0), FULL=(1,1). (0,1) is illegal; assert on it.
- EMPTY: on accept, load main and go to ONE; otherwise stay.
- ONE, accept & drain: main <= input; stay ONE.
- ONE, accept & !drain: skid <= input; go FULL (in_ready=0 next cycle).
- ONE, !accept & drain: go EMPTY. ONE, neither: hold.
- FULL (no accept possible): on drain, main <= skid, skid_valid <= 0, go ONE; otherwise hold.
- Latency: 1 cycle from accept to out_valid when empty. Throughput: 1 per cycle with out_ready held high.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- Flush (priority below reset, above all else): next cycle main_valid=0 and skid_valid=0; the same-cycle input is dropped even if accepted. A drain in the flush cycle still counts as a completed transfer downstream. Data flops need not clear.
- Reset: main_valid=0, skid_valid=0, in_ready=1 on the next cycle, out_ctrl=BUBBLE_CTRL, out_data=0, stall_count=0. Reset mid-FULL discards both entries.
- stall_count: increments by 1 on each cycle with out_valid & !out_ready; saturates at all-ones with no wrap.
- Count priority: reset/clear_count > increment. flush does not affect stall_count.
- No X propagation: data and ctrl flops load only on their enables.

Test Plan:
- Reset, then in_valid=1 with in_data=0x...0040 and in_ctrl=0x000123, out_ready=1 -> out_valid=1 one cycle later with out_data=0x...0040 and out_ctrl=0x000123; in_ready stays 1.
- Streaming: 8 back-to-back inputs 1..8 with out_ready=1 -> outputs 1..8 on consecutive cycles, no gaps, stall_count=0.
- Backpressure: out_ready=0 while sending A, B, C -> A on the outputs, B in skid, in_ready=0 after B, C held upstream. Raise out_ready -> A, B, C emitted in order; stall_count equals the number of cycles A waited.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, in_ready=1; flushed entries never appear.
- Hold out_ready=0 with out_valid=1 for 70000 cycles at COUNT_WIDTH=16 -> stall_count stops at 0xFFFF. Pulse clear_count -> 0.
- Assert reset while FULL -> next cycle out_valid=0, in_ready=1, stall_count=0, out_data=0.
